ets_mem_router: RTL and testbench
=================================

// Module: ets_mem_router
// PURPOSE
// - Parametrised replacement for the fixed two-way memory split in the ETS SoC top: routes the PicoRV32
//   native memory bus (valid/ready) to NUM_SLV address regions (BRAM, ETS regs, peripherals).
// - Adds a registered response path, per-transaction bus timeout with error response, and an exact
//   per-transaction latency record (cycles, pc/addr, fetch flag) for the ETS monitor.
// - Sits between the core and all slaves; ETS monitor consumes txn_* outputs.
// PARAMETERS
// - NUM_SLV      4                   number of downstream slave regions (1..8)
// - SLV_BASE     {NUM_SLV{32'h0}}    flattened bases, slave i at [32*i +: 32]
// - SLV_MASK     {NUM_SLV{32'h0}}    flattened masks; hit_i = (addr & MASK_i) == BASE_i
// - TIMEOUT_CYC  255                 max REQ cycles without slave ready before error (>=1)
// - CNT_W        16                  width of txn_cycles (saturating)
// - ERR_RDATA    32'hDEAD_BEEF       read data returned on error response
// PORTS
// - clk            in   1            clock
// - rst_n          in   1            synchronous reset, active low
// - up_valid/up_instr  in 1/1         core request valid / instruction-fetch flag
// - up_addr/up_wdata   in 32/32       core address / write data
// - up_wstrb       in   4            byte strobes; 0 = read
// - up_ready       out  1            one-cycle response strobe to core
// - up_rdata       out  32           registered response data
// - slv_valid      out  NUM_SLV      one-hot request to selected slave
// - slv_addr/slv_wdata out 32/32      registered request address / data, broadcast to all slaves
// - slv_wstrb      out  4            registered strobes, broadcast
// - slv_ready      in   NUM_SLV      per-slave ready
// - slv_rdata      in   32*NUM_SLV   flattened per-slave read data
// - txn_done       out  1            pulse in RESP cycle: txn_* fields valid
// - txn_cycles     out  CNT_W        latency of finished transaction
// - txn_addr/txn_instr/txn_err out 32/1/1  address, fetch flag, error flag of finished txn
// - bus_err        out  1            pulse on timeout or unmapped access
// - err_cnt        out  8            saturating error count
// BEHAVIOUR
// - Reset (sync, rst_n=0 at edge): state IDLE; all outputs 0 (up_rdata, slv_*, txn_*, err_cnt included).
//   Reset mid-transaction abandons it: slv_valid and up_ready 0 from next edge, no txn_done.
// - FSM IDLE -> REQ -> RESP -> IDLE; IDLE -> RESP on unmapped.
// - IDLE: on up_valid, register addr/wdata/wstrb/instr, decode; lowest-index hit wins on overlap.
//   Hit -> REQ with slv_valid[sel]=1 next cycle. No hit -> RESP with error.
// - REQ: slv_valid[sel] held; slv_ready[sel] sampled: capture slv_rdata[sel] into up_rdata, -> RESP.
//   Ready from non-selected slaves ignored. Timeout counter increments per REQ cycle; after
//   TIMEOUT_CYC cycles without ready -> RESP with error; slv_valid drops same edge.
// - RESP: up_ready=1, txn_done=1 for exactly one cycle; slv_valid=0; -> IDLE. On error: up_rdata=ERR_RDATA,
//   txn_err=1, bus_err=1, err_cnt+1 (saturates at 255). Writes ignore up_rdata.
// - Latency: zero-wait slave gives up_ready 2 cycles after the accept cycle; txn_cycles counts accept
//   cycle through RESP inclusive (0-wait = 3; unmapped = 2; timeout = TIMEOUT_CYC+2); saturates at 2^CNT_W-1.
// - txn_* fields hold their value until next txn_done. up_valid in RESP cycle is not accepted;
//   core must present a new request (valid re-sampled in IDLE).
// - slv_addr/wdata/wstrb stable from REQ entry to RESP exit.
// STRUCTURE
// - Shared include ets_bus_defs.vh: state encodings (IDLE/REQ/RESP), ERR_RDATA default, slave index width.
// - Sub-module ets_addr_decoder: combinational priority match of addr vs SLV_BASE/SLV_MASK -> sel, hit.
// - Top holds FSM, timeout and latency counters, response/txn registers.
// TESTING
// - 2 slaves (0: base 0 mask F000_0000, 1: base 8000_0000 mask FFFF_0000), 0-wait read 0x100 ->
//   up_ready 2 cycles after accept, up_rdata = slave0 data, txn_cycles=3, txn_instr=up_instr.
// - Write 0x8000_0004 wdata 0x5A, slave1 ready after 4 wait cycles -> slv_wstrb=F, txn_cycles=7, no bus_err.
// - Read 0x4000_0000 (unmapped) -> no slv_valid, up_ready after 1 cycle, up_rdata=DEAD_BEEF, bus_err, err_cnt=1.
// - TIMEOUT_CYC=8, slave0 never ready -> slv_valid high exactly 8 cycles, then error response, txn_cycles=10.
// - Overlapping masks (both match) -> slave 0 selected; slave1 ready pulses ignored.
// - rst_n low during REQ -> next cycle slv_valid=0, up_ready=0, no txn_done; following read works normally.

Source files
------------

// File: rtl/ets_mem_router_pkg.sv
// Shared definitions for the ETS memory router: FSM states, error read data,
// and the width of the slave select index.
package ets_mem_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;
    localparam int unsigned SLV_IDX_W     = 3;

endpackage

// File: rtl/ets_mem_router_addr_decoder.sv
// Combinational region decoder: first slave whose (addr & mask) == base wins.
module ets_addr_decoder
    import ets_mem_router_pkg::*;
#(
    parameter int unsigned           NUM_SLV  = 4,
    parameter logic [32*NUM_SLV-1:0] SLV_BASE = {NUM_SLV{32'h0}},
    parameter logic [32*NUM_SLV-1:0] SLV_MASK = {NUM_SLV{32'h0}}
) (
    input  logic [31:0]          addr,
    output logic [SLV_IDX_W-1:0] sel,
    output logic                 hit
);

    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (!hit && ((addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32])) begin
                hit = 1'b1;
                sel = SLV_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ets_mem_router.sv
// Routes the PicoRV32 native bus to NUM_SLV regions with registered response,
// per-transaction timeout/error response and a latency record for the ETS monitor.
module ets_mem_router
    import ets_mem_router_pkg::*;
#(
    parameter int unsigned           NUM_SLV     = 4,
    parameter logic [32*NUM_SLV-1:0] SLV_BASE    = {NUM_SLV{32'h0}},
    parameter logic [32*NUM_SLV-1:0] SLV_MASK    = {NUM_SLV{32'h0}},
    parameter int unsigned           TIMEOUT_CYC = 255,
    parameter int unsigned           CNT_W       = 16,
    parameter logic [31:0]           ERR_RDATA   = ERR_RDATA_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   up_valid,
    input  logic                   up_instr,
    input  logic [31:0]            up_addr,
    input  logic [31:0]            up_wdata,
    input  logic [3:0]             up_wstrb,
    output logic                   up_ready,
    output logic [31:0]            up_rdata,
    output logic [NUM_SLV-1:0]     slv_valid,
    output logic [31:0]            slv_addr,
    output logic [31:0]            slv_wdata,
    output logic [3:0]             slv_wstrb,
    input  logic [NUM_SLV-1:0]     slv_ready,
    input  logic [32*NUM_SLV-1:0]  slv_rdata,
    output logic                   txn_done,
    output logic [CNT_W-1:0]       txn_cycles,
    output logic [31:0]            txn_addr,
    output logic                   txn_instr,
    output logic                   txn_err,
    output logic                   bus_err,
    output logic [7:0]             err_cnt
);

    state_t                 state_q, state_d;
    logic [SLV_IDX_W-1:0]   sel, sel_q;
    logic                   hit;
    logic                   rdy_sel;
    logic [31:0]            rdata_sel;
    logic [31:0]            wait_cnt;
    logic [CNT_W-1:0]       lat_cnt;
    logic                   instr_q;
    logic                   timeout;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(b);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    ets_addr_decoder #(
        .NUM_SLV  (NUM_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_dec (
        .addr (up_addr),
        .sel  (sel),
        .hit  (hit)
    );

    always_comb begin
        rdy_sel   = 1'b0;
        rdata_sel = '0;
        slv_valid = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (sel_q == SLV_IDX_W'(i)) begin
                rdy_sel   = slv_ready[i];
                rdata_sel = slv_rdata[32*i +: 32];
                slv_valid[i] = (state_q == ST_REQ);
            end
        end
    end

    assign timeout = (wait_cnt == TIMEOUT_CYC - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        up_ready = 1'b0;
        txn_done = 1'b0;
        bus_err  = 1'b0;
        unique case (state_q)
            ST_IDLE: if (up_valid) state_d = hit ? ST_REQ : ST_RESP;
            ST_REQ:  if (rdy_sel || timeout) state_d = ST_RESP;
            ST_RESP: begin
                state_d  = ST_IDLE;
                up_ready = 1'b1;
                txn_done = 1'b1;
                bus_err  = txn_err;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // txn_* are loaded on the edge into RESP so they are valid alongside txn_done;
    // lat_cnt already includes the accept cycle, the +2 covers the final REQ/IDLE and RESP cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            up_rdata   <= '0;
            slv_addr   <= '0;
            slv_wdata  <= '0;
            slv_wstrb  <= '0;
            sel_q      <= '0;
            instr_q    <= 1'b0;
            wait_cnt   <= '0;
            lat_cnt    <= '0;
            txn_cycles <= '0;
            txn_addr   <= '0;
            txn_instr  <= 1'b0;
            txn_err    <= 1'b0;
            err_cnt    <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    wait_cnt <= '0;
                    if (up_valid) begin
                        slv_addr  <= up_addr;
                        slv_wdata <= up_wdata;
                        slv_wstrb <= up_wstrb;
                        instr_q   <= up_instr;
                        sel_q     <= sel;
                        lat_cnt   <= CNT_W'(1);
                        if (!hit) begin
                            up_rdata   <= ERR_RDATA;
                            txn_cycles <= sat_add('0, 2'd2);
                            txn_addr   <= up_addr;
                            txn_instr  <= up_instr;
                            txn_err    <= 1'b1;
                            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                        end
                    end
                end
                ST_REQ: begin
                    if (rdy_sel || timeout) begin
                        up_rdata   <= rdy_sel ? rdata_sel : ERR_RDATA;
                        txn_cycles <= sat_add(lat_cnt, 2'd2);
                        txn_addr   <= slv_addr;
                        txn_instr  <= instr_q;
                        txn_err    <= !rdy_sel;
                        if (!rdy_sel && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                        lat_cnt  <= sat_add(lat_cnt, 2'd1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ets_mem_router.sv
// Scoreboard bench for ets_mem_router: directed transactions push expected responses,
// a monitor pops and compares on every up_ready.
module tb_ets_mem_router;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  up_valid_v = '0;
    logic        up_instr = 1'b0;
    logic [31:0] up_addr = '0;
    logic [31:0] up_wdata = '0;
    logic [3:0]  up_wstrb = '0;
    logic [1:0]  slv_ready = '0;
    logic [63:0] slv_rdata = {32'hC0DE_0001, 32'hC0DE_0000};

    logic        up_ready_v   [2];
    logic [31:0] up_rdata_v   [2];
    logic [1:0]  slv_valid_v  [2];
    logic [31:0] slv_addr_v   [2];
    logic [31:0] slv_wdata_v  [2];
    logic [3:0]  slv_wstrb_v  [2];
    logic        txn_done_v   [2];
    logic [15:0] txn_cycles_v [2];
    logic [31:0] txn_addr_v   [2];
    logic        txn_instr_v  [2];
    logic        txn_err_v    [2];
    logic        bus_err_v    [2];
    logic [7:0]  err_cnt_v    [2];

    // Slave behaviour: ready after wait_cfg REQ cycles, never if never_rdy, force_rdy pulses regardless.
    int unsigned wait_cfg [2] = '{0, 0};
    int unsigned scnt     [2] = '{0, 0};
    bit [1:0]    never_rdy = '0;
    bit [1:0]    force_rdy = '0;

    typedef struct {
        int          dut;
        logic [31:0] rdata;
        bit          chk_rdata;
        int unsigned cyc;
        bit          instr;
        bit          err;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        bit          chk_slv;
        logic [7:0]  errcnt;
        int unsigned vcnt;
        logic [1:0]  vmask;
        int unsigned acc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc = 0;
    int unsigned resp_cnt = 0;
    int unsigned vcnt = 0;
    logic [1:0]  vmask = '0;

    always #5 clk = ~clk;

    ets_mem_router #(
        .NUM_SLV     (2),
        .SLV_BASE    ({32'h8000_0000, 32'h0000_0000}),
        .SLV_MASK    ({32'hFFFF_0000, 32'hF000_0000}),
        .TIMEOUT_CYC (8),
        .CNT_W       (16),
        .ERR_RDATA   (32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .up_valid(up_valid_v[0]), .up_instr(up_instr),
        .up_addr(up_addr), .up_wdata(up_wdata), .up_wstrb(up_wstrb),
        .up_ready(up_ready_v[0]), .up_rdata(up_rdata_v[0]), .slv_valid(slv_valid_v[0]),
        .slv_addr(slv_addr_v[0]), .slv_wdata(slv_wdata_v[0]), .slv_wstrb(slv_wstrb_v[0]),
        .slv_ready(slv_ready), .slv_rdata(slv_rdata), .txn_done(txn_done_v[0]),
        .txn_cycles(txn_cycles_v[0]), .txn_addr(txn_addr_v[0]), .txn_instr(txn_instr_v[0]),
        .txn_err(txn_err_v[0]), .bus_err(bus_err_v[0]), .err_cnt(err_cnt_v[0])
    );

    // Fully overlapping regions: every address hits both slaves.
    ets_mem_router #(
        .NUM_SLV     (2),
        .SLV_BASE    ({32'h0, 32'h0}),
        .SLV_MASK    ({32'h0, 32'h0}),
        .TIMEOUT_CYC (8),
        .CNT_W       (16),
        .ERR_RDATA   (32'hDEAD_BEEF)
    ) dut_ovl (
        .clk(clk), .rst_n(rst_n), .up_valid(up_valid_v[1]), .up_instr(up_instr),
        .up_addr(up_addr), .up_wdata(up_wdata), .up_wstrb(up_wstrb),
        .up_ready(up_ready_v[1]), .up_rdata(up_rdata_v[1]), .slv_valid(slv_valid_v[1]),
        .slv_addr(slv_addr_v[1]), .slv_wdata(slv_wdata_v[1]), .slv_wstrb(slv_wstrb_v[1]),
        .slv_ready(slv_ready), .slv_rdata(slv_rdata), .txn_done(txn_done_v[1]),
        .txn_cycles(txn_cycles_v[1]), .txn_addr(txn_addr_v[1]), .txn_instr(txn_instr_v[1]),
        .txn_err(txn_err_v[1]), .bus_err(bus_err_v[1]), .err_cnt(err_cnt_v[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int d, input logic [31:0] rd, input bit crd,
                                input int unsigned cy, input bit ins, input bit er,
                                input logic [31:0] a, input logic [3:0] ws, input bit cs,
                                input logic [7:0] ec, input int unsigned vc, input logic [1:0] vm);
        exp_t e;
        e.dut = d; e.rdata = rd; e.chk_rdata = crd; e.cyc = cy; e.instr = ins; e.err = er;
        e.addr = a; e.wstrb = ws; e.chk_slv = cs; e.errcnt = ec; e.vcnt = vc; e.vmask = vm;
        e.acc = 0;
        return e;
    endfunction

    task automatic issue(input int d, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input bit ins, input exp_t e);
        int unsigned n;
        @(negedge clk);
        up_addr = a; up_wdata = wd; up_wstrb = ws; up_instr = ins;
        e.acc = cyc;
        exp_q.push_back(e);
        n = resp_cnt;
        up_valid_v[d] = 1'b1;
        @(negedge clk);
        up_valid_v[d] = 1'b0;
        for (int i = 0; i < 60 && resp_cnt == n; i++) @(negedge clk);
        if (resp_cnt == n) begin
            tests++;
            fails++;
            $display("FAIL resp_timeout: no up_ready for addr %h within 60 cycles", a);
            exp_q.delete();
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (slv_valid_v[0][i] | slv_valid_v[1][i]) begin
                slv_ready[i] = (!never_rdy[i] && scnt[i] == wait_cfg[i]) || force_rdy[i];
                scnt[i]++;
            end else begin
                scnt[i] = 0;
                slv_ready[i] = force_rdy[i];
            end
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            vcnt = 0;
            vmask = '0;
        end else begin
            if ((slv_valid_v[0] | slv_valid_v[1]) != 2'b00) vcnt++;
            vmask = vmask | slv_valid_v[0] | slv_valid_v[1];
            for (int d = 0; d < 2; d++) begin
                if (up_ready_v[d]) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_resp: up_ready on dut %0d with nothing outstanding", d);
                    end else begin
                        e = exp_q.pop_front();
                        chk("resp_dut",   32'(d), 32'(e.dut));
                        chk("latency",    cyc - e.acc, e.cyc - 1);
                        if (e.chk_rdata) chk("up_rdata", up_rdata_v[d], e.rdata);
                        chk("txn_done",   32'(txn_done_v[d]), 32'd1);
                        chk("txn_cycles", 32'(txn_cycles_v[d]), e.cyc);
                        chk("txn_instr",  32'(txn_instr_v[d]), 32'(e.instr));
                        chk("txn_err",    32'(txn_err_v[d]), 32'(e.err));
                        chk("txn_addr",   txn_addr_v[d], e.addr);
                        chk("bus_err",    32'(bus_err_v[d]), 32'(e.err));
                        chk("err_cnt",    32'(err_cnt_v[d]), 32'(e.errcnt));
                        chk("valid_cycles", vcnt, e.vcnt);
                        chk("valid_mask", 32'(vmask), 32'(e.vmask));
                        if (e.chk_slv) begin
                            chk("slv_addr",  slv_addr_v[d], e.addr);
                            chk("slv_wstrb", 32'(slv_wstrb_v[d]), 32'(e.wstrb));
                        end
                    end
                    vcnt = 0;
                    vmask = '0;
                    resp_cnt++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_up_ready",   32'(up_ready_v[0]), 32'd0);
        chk("rst_up_rdata",   up_rdata_v[0], 32'd0);
        chk("rst_slv_valid",  32'(slv_valid_v[0]), 32'd0);
        chk("rst_slv_addr",   slv_addr_v[0], 32'd0);
        chk("rst_txn_done",   32'(txn_done_v[0]), 32'd0);
        chk("rst_txn_cycles", 32'(txn_cycles_v[0]), 32'd0);
        chk("rst_err_cnt",    32'(err_cnt_v[0]), 32'd0);
        rst_n = 1'b1;

        // zero-wait instruction fetch from slave 0
        issue(0, 32'h0000_0100, 32'h0, 4'h0, 1'b1,
              mk(0, 32'hC0DE_0000, 1, 3, 1, 0, 32'h0000_0100, 4'h0, 1, 8'd0, 1, 2'b01));

        // write to slave 1 with 4 wait cycles
        wait_cfg[1] = 4;
        issue(0, 32'h8000_0004, 32'h0000_005A, 4'hF, 1'b0,
              mk(0, 32'h0, 0, 7, 0, 0, 32'h8000_0004, 4'hF, 1, 8'd0, 5, 2'b10));
        chk("slv_wdata", slv_wdata_v[0], 32'h0000_005A);
        wait_cfg[1] = 0;

        // unmapped read
        issue(0, 32'h4000_0000, 32'h0, 4'h0, 1'b0,
              mk(0, 32'hDEAD_BEEF, 1, 2, 0, 1, 32'h4000_0000, 4'h0, 0, 8'd1, 0, 2'b00));

        // slave 0 never ready: timeout after 8 REQ cycles
        never_rdy[0] = 1'b1;
        issue(0, 32'h0000_0200, 32'h0, 4'h0, 1'b0,
              mk(0, 32'hDEAD_BEEF, 1, 10, 0, 1, 32'h0000_0200, 4'h0, 1, 8'd2, 8, 2'b01));
        never_rdy[0] = 1'b0;

        // overlapping regions: slave 0 wins, slave 1 ready held high is ignored
        wait_cfg[0] = 3;
        force_rdy[1] = 1'b1;
        issue(1, 32'h0000_1234, 32'h0, 4'h0, 1'b1,
              mk(1, 32'hC0DE_0000, 1, 6, 1, 0, 32'h0000_1234, 4'h0, 1, 8'd0, 4, 2'b01));
        force_rdy[1] = 1'b0;
        wait_cfg[0] = 0;

        // reset while in REQ abandons the transaction
        @(negedge clk);
        never_rdy[0] = 1'b1;
        up_addr = 32'h0000_0300; up_wstrb = 4'h0; up_instr = 1'b0;
        up_valid_v[0] = 1'b1;
        @(negedge clk);
        up_valid_v[0] = 1'b0;
        @(negedge clk);
        chk("abort_slv_valid_req", 32'(slv_valid_v[0]), 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_slv_valid", 32'(slv_valid_v[0]), 32'd0);
        chk("abort_up_ready",  32'(up_ready_v[0]), 32'd0);
        chk("abort_txn_done",  32'(txn_done_v[0]), 32'd0);
        chk("abort_err_cnt",   32'(err_cnt_v[0]), 32'd0);
        rst_n = 1'b1;
        never_rdy[0] = 1'b0;
        repeat (4) @(negedge clk);

        // normal read after reset, to slave 1
        issue(0, 32'h8000_0010, 32'h0, 4'h0, 1'b1,
              mk(0, 32'hC0DE_0001, 1, 3, 1, 0, 32'h8000_0010, 4'h0, 1, 8'd0, 1, 2'b10));

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL leftover_expect: %0d responses never seen", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
